// File: rtl/dcc_packet_scheduler.sv
// dcc_packet_scheduler
// Serialises DCC packets (preamble, start/data bytes, checksum, end bit) for a
// bit encoder that handshakes with a level bit_ack. Two requesters share the
// line through round-robin arbitration that happens only at packet boundaries.
// When nobody is granted, an idle packet (FF, 00, checksum FF) is sent.
module dcc_packet_scheduler #(
   parameter int PREAMBLE_BITS = 14
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        bit_ack,
   input  logic        req0,
   input  logic        req1,
   input  logic [1:0]  len0,
   input  logic [1:0]  len1,
   input  logic [23:0] data0,
   input  logic [23:0] data1,
   output logic        next_bit,
   output logic        grant0,
   output logic        grant1,
   output logic        done0,
   output logic        done1,
   output logic        busy
);

   localparam logic [4:0]  PRE_LAST  = 5'(PREAMBLE_BITS - 1);
   localparam logic [1:0]  IDLE_LEN  = 2'd2;
   localparam logic [23:0] IDLE_DATA = 24'hFF_00_00;

   typedef enum logic [1:0] {
      S_PRE,
      S_START,
      S_DATA,
      S_END
   } state_t;

   state_t      state, state_nx;
   logic [4:0]  pre_cnt, pre_cnt_nx;
   logic [2:0]  bit_cnt, bit_cnt_nx, bit_inc;
   logic [1:0]  byte_cnt, byte_cnt_nx;
   logic        next_bit_nx;

   logic        ack_q;
   logic        adv;
   logic        arb_pend;
   logic        arb;
   logic        any_req;
   logic        sel;
   logic        pri;
   logic        owner;
   logic        active;
   logic [1:0]  pkt_len;
   logic [23:0] pkt_data;
   logic [7:0]  data_byte;
   logic [7:0]  csum;
   logic [7:0]  cur_byte;
   logic        end_adv;

   // Rising edge of bit_ack: the encoder has taken the bit on next_bit.
   always_ff @(posedge clk) begin
      ack_q <= bit_ack;
   end

   assign adv     = bit_ack & ~ack_q;
   assign end_adv = adv && (state == S_END);

   // Arbitration happens on the first cycle out of reset and on every END advance.
   assign arb     = !reset && (arb_pend || end_adv);
   assign any_req = req0 | req1;
   assign sel     = (req0 && req1) ? pri : req1;

   assign grant0  = arb && any_req && !sel;
   assign grant1  = arb && any_req &&  sel;
   assign done0   = !reset && end_adv && active && !owner;
   assign done1   = !reset && end_adv && active &&  owner;
   assign busy    = active;

   // Byte currently being serialised: a latched data byte or the checksum,
   // which follows the last data byte (byte index equal to the length).
   always_comb begin
      data_byte = 8'h00;
      case (byte_cnt)
         2'd0:    data_byte = pkt_data[23:16];
         2'd1:    data_byte = pkt_data[15:8];
         2'd2:    data_byte = pkt_data[7:0];
         default: data_byte = 8'h00;
      endcase
      csum = pkt_data[23:16]
           ^ ((pkt_len >= 2'd2) ? pkt_data[15:8] : 8'h00)
           ^ ((pkt_len == 2'd3) ? pkt_data[7:0]  : 8'h00);
      cur_byte = (byte_cnt == pkt_len) ? csum : data_byte;
   end

   assign bit_inc = bit_cnt + 3'd1;

   // Next-state: one packet bit per advance; next_bit holds the bit the
   // encoder will take on its next ack.
   always_comb begin
      state_nx    = state;
      pre_cnt_nx  = pre_cnt;
      bit_cnt_nx  = bit_cnt;
      byte_cnt_nx = byte_cnt;
      next_bit_nx = next_bit;
      if (adv) begin
         case (state)
            S_PRE: begin
               if (pre_cnt == PRE_LAST) begin
                  state_nx    = S_START;
                  pre_cnt_nx  = 5'd0;
                  next_bit_nx = 1'b0;
               end else begin
                  pre_cnt_nx  = pre_cnt + 5'd1;
                  next_bit_nx = 1'b1;
               end
            end
            S_START: begin
               state_nx    = S_DATA;
               bit_cnt_nx  = 3'd0;
               next_bit_nx = cur_byte[7];
            end
            S_DATA: begin
               if (bit_cnt == 3'd7) begin
                  bit_cnt_nx  = 3'd0;
                  byte_cnt_nx = byte_cnt + 2'd1;
                  if (byte_cnt == pkt_len) begin
                     state_nx    = S_END;
                     next_bit_nx = 1'b1;
                  end else begin
                     state_nx    = S_START;
                     next_bit_nx = 1'b0;
                  end
               end else begin
                  bit_cnt_nx  = bit_inc;
                  // MSB first: bit index 7-n is the bitwise complement of n.
                  next_bit_nx = cur_byte[~bit_inc];
               end
            end
            S_END: begin
               state_nx    = S_PRE;
               pre_cnt_nx  = 5'd0;
               byte_cnt_nx = 2'd0;
               next_bit_nx = 1'b1;
            end
            default: begin
               state_nx    = S_PRE;
               pre_cnt_nx  = 5'd0;
               byte_cnt_nx = 2'd0;
               next_bit_nx = 1'b1;
            end
         endcase
      end
   end

   // Serialiser state register; reset aborts any packet and restarts the preamble.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_PRE;
         pre_cnt  <= 5'd0;
         bit_cnt  <= 3'd0;
         byte_cnt <= 2'd0;
         next_bit <= 1'b1;
      end else begin
         state    <= state_nx;
         pre_cnt  <= pre_cnt_nx;
         bit_cnt  <= bit_cnt_nx;
         byte_cnt <= byte_cnt_nx;
         next_bit <= next_bit_nx;
      end
   end

   // Arbitration: latch the winner's packet (or the idle packet) for the
   // whole next packet and rotate priority away from the winner.
   always_ff @(posedge clk) begin
      if (reset) begin
         arb_pend <= 1'b1;
         pri      <= 1'b0;
         owner    <= 1'b0;
         active   <= 1'b0;
         pkt_len  <= IDLE_LEN;
         pkt_data <= IDLE_DATA;
      end else begin
         arb_pend <= 1'b0;
         if (arb) begin
            if (any_req) begin
               owner  <= sel;
               active <= 1'b1;
               pri    <= ~sel;
               if ((sel ? len1 : len0) == 2'd0) begin
                  pkt_len  <= IDLE_LEN;
                  pkt_data <= IDLE_DATA;
               end else begin
                  pkt_len  <= sel ? len1  : len0;
                  pkt_data <= sel ? data1 : data0;
               end
            end else begin
               active   <= 1'b0;
               pkt_len  <= IDLE_LEN;
               pkt_data <= IDLE_DATA;
            end
         end
      end
   end

endmodule

// File: tb/tb_dcc_packet_scheduler.sv
// Bench for dcc_packet_scheduler: table of packet-level vectors followed by
// random packets, each checked bit-by-bit against a packet builder model,
// plus a hand-written mid-packet reset sequence.
module tb_dcc_packet_scheduler;

   localparam int PRE = 14;
   localparam int NT  = 10;
   localparam int NR  = 25;

   logic        clk = 1'b0;
   logic        reset, bit_ack, req0, req1;
   logic [1:0]  len0, len1;
   logic [23:0] data0, data1;
   logic        next_bit, grant0, grant1, done0, done1, busy;

   dcc_packet_scheduler #(.PREAMBLE_BITS(PRE)) dut (
      .clk(clk), .reset(reset), .bit_ack(bit_ack),
      .req0(req0), .req1(req1), .len0(len0), .len1(len1),
      .data0(data0), .data1(data1), .next_bit(next_bit),
      .grant0(grant0), .grant1(grant1), .done0(done0), .done1(done1),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        r0, r1;
      logic [1:0]  l0, l1;
      logic [23:0] d0, d1;
      int          gnt;
      logic [7:0]  csum;
      logic        drop;
   } vec_t;

   int         checks = 0;
   int         errors = 0;
   bit         exp_q[$];
   logic [7:0] exp_cs;
   int         m_pri = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic int enc(input int g);
      return (g == 0) ? 1 : (g == 1) ? 2 : 0;
   endfunction

   // Reference arbitration: both requesting -> the one that did not win last.
   function automatic int arb_model(input logic r0, input logic r1);
      if (r0 && r1) return m_pri;
      if (r0) return 0;
      if (r1) return 1;
      return -1;
   endfunction

   // Reference packet: list of bytes plus XOR checksum, framed as bits.
   task automatic build(input int own, input logic [1:0] l, input logic [23:0] d);
      logic [7:0] by[$];
      exp_q.delete();
      if (own < 0 || l == 2'd0) by = '{8'hFF, 8'h00};
      else for (int b = 0; b < int'(l); b++) by.push_back(d[23-8*b -: 8]);
      exp_cs = 8'h00;
      foreach (by[b]) exp_cs ^= by[b];
      by.push_back(exp_cs);
      repeat (PRE) exp_q.push_back(1'b1);
      foreach (by[b]) begin
         exp_q.push_back(1'b0);
         for (int j = 7; j >= 0; j--) exp_q.push_back(by[b][j]);
      end
      exp_q.push_back(1'b1);
   endtask

   task automatic set_in(input vec_t v);
      req0 = v.r0; req1 = v.r1; len0 = v.l0; len1 = v.l1; data0 = v.d0; data1 = v.d1;
   endtask

   // One encoder handshake, starting and ending on a falling edge.
   task automatic pulse_ack(output logic g0, output logic g1, output logic dn0, output logic dn1);
      bit_ack = 1'b1;
      #1;
      g0 = grant0; g1 = grant1; dn0 = done0; dn1 = done1;
      @(negedge clk);
      bit_ack = 1'b0;
      @(negedge clk);
   endtask

   // Play one whole packet; the next arbitration inputs go on just before END.
   task automatic play(input int own, input logic [1:0] l, input logic [23:0] d,
                       input vec_t nxt, input int nxt_g, output logic [7:0] rx_cs);
      int n;
      logic g0, g1, dn0, dn1;
      build(own, l, d);
      n = exp_q.size();
      rx_cs = 8'h00;
      chk("busy_pkt", busy, (own >= 0) ? 1 : 0);
      for (int k = 0; k < n; k++) begin
         chk("bit", next_bit, exp_q[k]);
         if (k >= n-9 && k < n-1) rx_cs = {rx_cs[6:0], next_bit};
         if (k == n-1) set_in(nxt);
         pulse_ack(g0, g1, dn0, dn1);
         if (k < n-1) chk("quiet", {g0, g1, dn0, dn1}, 0);
         else begin
            chk("done",  {dn1, dn0}, enc(own));
            chk("grant", {g1, g0},   enc(nxt_g));
         end
      end
      chk("busy_after", busy, (nxt_g >= 0) ? 1 : 0);
      chk("csum_model", rx_cs, exp_cs);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[NT];
      vec_t plan[$];
      vec_t zv, cur, nxt;
      int   own, nxt_g, n;
      logic [1:0]  l;
      logic [23:0] d;
      logic [7:0]  rx;
      logic g0, g1, dn0, dn1;

      //          r0 r1 l0    l1    d0          d1          gnt csum   drop
      tbl[0] = '{1, 0, 2'd2, 2'd0, 24'h033F00, 24'h000000,  0, 8'h3C, 0};
      tbl[1] = '{1, 1, 2'd1, 2'd1, 24'hA50000, 24'h5A0000,  1, 8'h5A, 0};
      tbl[2] = '{1, 1, 2'd1, 2'd1, 24'hA50000, 24'h5A0000,  0, 8'hA5, 0};
      tbl[3] = '{1, 1, 2'd1, 2'd1, 24'hA50000, 24'h5A0000,  1, 8'h5A, 0};
      tbl[4] = '{0, 1, 2'd0, 2'd0, 24'h000000, 24'h123456,  1, 8'hFF, 0};
      tbl[5] = '{0, 0, 2'd3, 2'd3, 24'h111111, 24'h222222, -1, 8'hFF, 0};
      tbl[6] = '{0, 0, 2'd0, 2'd0, 24'h000000, 24'h000000, -1, 8'hFF, 0};
      tbl[7] = '{1, 0, 2'd3, 2'd0, 24'h123456, 24'h000000,  0, 8'h70, 1};
      tbl[8] = '{1, 1, 2'd3, 2'd2, 24'h123456, 24'hC3A0FF,  1, 8'h63, 0};
      tbl[9] = '{1, 0, 2'd1, 2'd0, 24'h000000, 24'hFFFFFF,  0, 8'h00, 0};
      for (int i = 0; i < NT; i++) plan.push_back(tbl[i]);
      for (int i = 0; i < NR; i++) begin
         vec_t v;
         v.r0 = 1'($urandom_range(0, 1)); v.r1 = 1'($urandom_range(0, 1));
         v.l0 = 2'($urandom_range(0, 3)); v.l1 = 2'($urandom_range(0, 3));
         v.d0 = 24'($urandom);            v.d1 = 24'($urandom);
         v.gnt = 0; v.csum = 8'h00;
         v.drop = 1'($urandom_range(0, 1));
         plan.push_back(v);
      end
      zv = '{0, 0, 2'd0, 2'd0, 24'h0, 24'h0, -1, 8'h00, 0};

      // Reset state
      bit_ack = 1'b0;
      set_in(plan[0]);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_next_bit", next_bit, 1);
      chk("rst_busy", busy, 0);
      chk("rst_grant", {grant1, grant0}, 0);
      chk("rst_done", {done1, done0}, 0);
      reset = 1'b0;
      #1;
      own = tbl[0].gnt;
      chk("grant_rst_exit", {grant1, grant0}, enc(own));
      if (own >= 0) m_pri = 1 - own;
      @(negedge clk);
      if (plan[0].drop) begin req0 = 1'b0; req1 = 1'b0; end

      // Table then random packets, back to back
      n = plan.size();
      for (int i = 0; i < n; i++) begin
         cur = plan[i];
         l = (own == 1) ? cur.l1 : cur.l0;
         d = (own == 1) ? cur.d1 : cur.d0;
         if (i + 1 < n) begin
            nxt   = plan[i+1];
            nxt_g = (i + 1 < NT) ? tbl[i+1].gnt : arb_model(nxt.r0, nxt.r1);
         end else begin
            nxt   = zv;
            nxt_g = -1;
         end
         play(own, l, d, nxt, nxt_g, rx);
         if (i < NT) chk("tbl_csum", rx, tbl[i].csum);
         if (nxt_g >= 0) m_pri = 1 - nxt_g;
         own = nxt_g;
         if (i + 1 < n && nxt.drop) begin req0 = 1'b0; req1 = 1'b0; end
      end

      // Reset during the second data byte: abort, no done, full preamble after
      req0 = 1'b1; req1 = 1'b0; len0 = 2'd2; data0 = 24'hF0F0F0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mid_grant", {grant1, grant0}, 1);
      @(negedge clk);
      build(0, 2'd2, 24'hF0F0F0);
      for (int k = 0; k < 28; k++) begin
         chk("mid_bit", next_bit, exp_q[k]);
         pulse_ack(g0, g1, dn0, dn1);
         chk("mid_quiet", {g0, g1, dn0, dn1}, 0);
      end
      req0 = 1'b0;
      reset = 1'b1;
      bit_ack = 1'b1;
      #1;
      chk("mid_rst_done", {done1, done0}, 0);
      @(negedge clk);
      chk("mid_rst_next_bit", next_bit, 1);
      chk("mid_rst_busy", busy, 0);
      bit_ack = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mid_rel_grant", {grant1, grant0}, 0);
      @(negedge clk);
      build(-1, 2'd0, 24'h0);
      for (int k = 0; k <= PRE; k++) begin
         chk("post_rst_bit", next_bit, exp_q[k]);
         pulse_ack(g0, g1, dn0, dn1);
         chk("post_rst_quiet", {g0, g1, dn0, dn1}, 0);
      end
      chk("post_rst_start", next_bit, exp_q[PRE+1]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dcc_packet_scheduler.md
DCC_PACKET_SCHEDULER -- requirements
Module: dcc_packet_scheduler

Interface
REQ-001 SHALL have parameter PREAMBLE_BITS, default 14, count of preamble '1' bits per packet (legal 14..31).
REQ-002 SHALL have port clk  input  1  system clock, sole clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port bit_ack  input  1  level from bit encoder; each rising edge means the encoder has consumed the current bit.
REQ-005 SHALL have port next_bit  output  1  bit the encoder samples after bit_ack.
REQ-006 SHALL have ports req0/req1  input  1  requester holds high until its done pulse.
REQ-007 SHALL have ports len0/len1  input  2  data byte count, 1..3; 0 means an empty request.
REQ-008 SHALL have ports data0/data1  input  24  data bytes; byte 0 in [23:16], sent first.
REQ-009 SHALL have ports grant0/grant1  output  1  one-clk pulse when that port's len/data are latched.
REQ-010 SHALL have ports done0/done1  output  1  one-clk pulse when that port's end bit is consumed.
REQ-011 SHALL have port busy  output  1  high while a requester packet (not idle packet) is in progress.

Function
REQ-012 SHALL detect a bit_ack rising edge by registering bit_ack once in clk and comparing; each detected edge is one "advance".
REQ-013 SHALL update next_bit on the clk edge following advance detection; next_bit stays stable otherwise.
REQ-014 SHALL step FSM states PREAMBLE -> START -> DATA -> (START -> DATA per further byte) -> END -> PREAMBLE, one state bit per advance.
REQ-015 PREAMBLE SHALL drive next_bit=1 for exactly PREAMBLE_BITS advances.
REQ-016 START SHALL drive next_bit=0 for one advance before every byte, including the checksum.
REQ-017 DATA SHALL drive 8 bits MSB first; a 3-bit bit counter wraps 7->0 and increments a 2-bit byte counter.
REQ-018 SHALL append a checksum byte equal to XOR of all sent data bytes after the last data byte.
REQ-019 END SHALL drive next_bit=1 for one advance.
REQ-020 Total bits per packet SHALL be PREAMBLE_BITS + 9*(len+1) + 1.
REQ-021 Arbitration SHALL occur only on entering PREAMBLE (reset exit or END advance); req/len/data changes at other times are ignored.
REQ-022 With both reqs high, SHALL grant the port not granted last (round robin); after reset port 0 has priority.
REQ-023 With no req high, SHALL send an idle packet: bytes 0xFF, 0x00, checksum 0xFF; no grant/done pulses.
REQ-024 A granted request with len=0 SHALL pulse grant and send an idle packet; done pulses at its END.
REQ-025 SHALL assert grantN in the same cycle data is latched; the latched copy is used for the whole packet.
REQ-026 SHALL pulse doneN on the clk cycle the END advance is detected; a new grant may occur in that same cycle.
REQ-027 A request withdrawn after grant SHALL not abort the packet; done still pulses.
REQ-028 busy SHALL rise with grant and fall with done, except stays high if a new grant occurs in the done cycle.

Reset
REQ-029 On reset: next_bit=1, grant0/1=0, done0/1=0, busy=0, FSM=PREAMBLE with count 0, round-robin pointer to port 0, bit_ack history cleared to current bit_ack.
REQ-030 Reset mid-packet SHALL abort it without done pulse; the following packet restarts from a full preamble.
REQ-031 Arbitration SHALL run in the first cycle after reset release.

Verification
REQ-032 No reqs, 60 bit_ack edges -> 14 ones, 0,0xFF,0,0x00,0,0xFF,1, repeating; no grant/done.
REQ-033 req0, len0=2, data0=0x033F00 -> grant0 pulse; bits 14x1,0,0x03,0,0x3F,0,0x3C,1 (42 bits); done0 on 42nd advance.
REQ-034 req0 and req1 held continuously, len=1 -> grants alternate 0,1,0,1; each done precedes next grant by 0 cycles.
REQ-035 req1 len1=0 -> grant1, idle-packet bit pattern, done1 at END.
REQ-036 reset asserted during 2nd data byte -> next_bit=1, no done; after release full 14-bit preamble before START.
